pe_dispatch: RTL and testbench

Sequential dispatcher that sits directly upstream of the PE 1:4 demux. It accepts a valid/ready stream of operands and buffers at most one operand. It then issues each operand to the next free PE lane in round-robin order, driving the demux select (s1, s0) and data input for one cycle per issue. It tracks per-lane busy state until each PE reports done.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_dispatch_if.sv | 53 +++++
 rtl/pe_rr_pick.sv | 40 ++++
 rtl/pe_dispatch.sv | 133 +++++++++++++
 tb/tb_pe_dispatch.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared types and constants for the PE dispatcher:
//                lane count, lane-index width and type, and the hold-register
//                FSM state encoding.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package pe_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef logic [LANE_W-1:0] lane_t;

    // EMPTY: nothing held.  PENDING: one operand waiting for a free lane.
    typedef enum logic [0:0] {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } state_e;

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_dispatch_if
//  Description : Bundle of the dispatcher's operand stream, PE completion
//                pulses and demux-facing outputs.
//  Signals     : in_valid/in_ready/in_data - upstream operand stream
//                pe_done[3:0]              - per-lane completion pulses
//                dout, s1, s0, dout_valid  - demux data, select, issue strobe
//                lane_busy[3:0]            - registered per-lane busy flags
//  Modports    : master - upstream/PE side (drives operands and done)
//                slave  - dispatcher side
//  Revision    : 1.0  initial release
// ============================================================================
interface pe_dispatch_if #(
    parameter int DATA_W = 1
);

    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_W-1:0]             in_data;
    logic [pe_pkg::NUM_LANES-1:0]  pe_done;
    logic [DATA_W-1:0]             dout;
    logic                          s0;
    logic                          s1;
    logic                          dout_valid;
    logic [pe_pkg::NUM_LANES-1:0]  lane_busy;

    modport master (
        output in_valid,
        output in_data,
        output pe_done,
        input  in_ready,
        input  dout,
        input  s0,
        input  s1,
        input  dout_valid,
        input  lane_busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  pe_done,
        output in_ready,
        output dout,
        output s0,
        output s1,
        output dout_valid,
        output lane_busy
    );

endinterface : pe_dispatch_if
`default_nettype wire

// File: rtl/pe_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : pe_rr_pick
//  Description : Combinational 4-way round-robin picker. Returns the first
//                free lane searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  Ports       : free_i[3:0]  - per-lane free flags
//                ptr_i[1:0]   - search start lane
//                lane_o[1:0]  - chosen lane (only meaningful if any_free_o)
//                any_free_o   - at least one lane is free
//  Revision    : 1.0  initial release
// ============================================================================
module pe_rr_pick
    import pe_pkg::*;
(
    input  wire logic [NUM_LANES-1:0] free_i,
    input  wire lane_t                ptr_i,
    output lane_t                     lane_o,
    output logic                      any_free_o
);

    logic  found;
    lane_t idx;

    always_comb begin
        lane_o = ptr_i;
        found  = 1'b0;
        idx    = ptr_i;
        for (int k = 0; k < NUM_LANES; k++) begin
            // 2-bit addition wraps naturally, giving the mod-4 search order.
            idx = ptr_i + lane_t'(k);
            if (!found && free_i[idx]) begin
                lane_o = idx;
                found  = 1'b1;
            end
        end
        any_free_o = |free_i;
    end

endmodule : pe_rr_pick
`default_nettype wire

// File: rtl/pe_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : pe_dispatch
//  Description : Sequential dispatcher upstream of the PE 1:4 demux. Buffers
//                one operand and issues it to the next free PE lane in
//                round-robin order, tracking per-lane busy state until the
//                PE reports done.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - pe_dispatch_if.slave (operand stream, pe_done,
//                       dout/s1/s0/dout_valid, lane_busy)
//  Revision    : 1.0  initial release
// ============================================================================
module pe_dispatch
    import pe_pkg::*;
#(
    parameter int DATA_W = 1
)(
    input  wire logic       clk,
    input  wire logic       rst,
    pe_dispatch_if.slave    bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q,      state_d;
    logic [DATA_W-1:0]      hold_data_q,  hold_data_d;
    lane_t                  ptr_q,        ptr_d;
    lane_t                  sel_q,        sel_d;
    logic [NUM_LANES-1:0]   busy_q,       busy_d;
    logic [DATA_W-1:0]      dout_q,       dout_d;
    logic                   dout_valid_q, dout_valid_d;

    // ------------------------------------------------------------------
    // Lane selection from registered busy flags only, so in_ready never
    // depends on same-cycle pe_done or in_valid.
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0]   free;
    lane_t                  pick_lane;
    logic                   any_free;

    assign free = ~busy_q;

    pe_rr_pick u_pick (
        .free_i     (free),
        .ptr_i      (ptr_q),
        .lane_o     (pick_lane),
        .any_free_o (any_free)
    );

    // ------------------------------------------------------------------
    // FSM output logic
    // ------------------------------------------------------------------
    logic in_ready;
    logic issue;
    logic accept;

    always_comb begin
        in_ready = (state_q == EMPTY) || any_free;
        issue    = (state_q == PENDING) && any_free;
        accept   = bus.in_valid && in_ready;
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = PENDING;
        end else if (issue) begin
            state_d = EMPTY;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        hold_data_d  = accept ? bus.in_data : hold_data_q;
        ptr_d        = ptr_q;
        sel_d        = sel_q;
        dout_d       = '0;
        dout_valid_d = 1'b0;
        // Releases only affect busy lanes; issue can never target a lane
        // being released since it must already be free.
        busy_d       = busy_q & ~bus.pe_done;

        if (issue) begin
            dout_d           = hold_data_q;
            dout_valid_d     = 1'b1;
            sel_d            = pick_lane;
            busy_d[pick_lane] = 1'b1;
            ptr_d            = pick_lane + lane_t'(1);
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            hold_data_q  <= '0;
            ptr_q        <= '0;
            sel_q        <= '0;
            busy_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = in_ready;
    assign bus.dout       = dout_q;
    assign bus.s1         = sel_q[1];
    assign bus.s0         = sel_q[0];
    assign bus.dout_valid = dout_valid_q;
    assign bus.lane_busy  = busy_q;

endmodule : pe_dispatch
`default_nettype wire

// File: tb/tb_pe_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_dispatch
//  Description : Self-checking bench for pe_dispatch (DATA_W=4). Operands are
//                pushed to a scoreboard when accepted and popped when issued;
//                lane choice and busy flags follow a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pe_dispatch;

    logic clk;
    logic rst;

    pe_dispatch_if #(.DATA_W(4)) bus ();

    pe_dispatch #(.DATA_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_bad;
    logic [3:0] sb[$];

    // Behavioural model of dispatcher state
    logic [3:0] mb;
    logic [1:0] mptr;
    logic       mpend;
    logic       last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] rr(input logic [3:0] fr, input logic [1:0] p);
        logic [1:0] r;
        logic [1:0] ix;
        logic       f;
        r = p;
        f = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ix = p + 2'(k);
            if (!f && fr[ix]) begin
                r = ix;
                f = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        mb    = 4'b0000;
        mptr  = 2'd0;
        mpend = 1'b0;
        sb.delete();
    endtask

    // One clock: drive inputs (called at posedge+1), check in_ready, advance,
    // then check registered outputs against the model and scoreboard.
    task automatic step(input logic v, input logic [3:0] d, input logic [3:0] done);
        logic       any;
        logic       rdy;
        logic       iss;
        logic       acc;
        logic [1:0] ln;
        logic [3:0] exp_d;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.pe_done  = done;
        any = |(~mb);
        rdy = !mpend || any;
        iss = mpend && any;
        ln  = rr(~mb, mptr);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        acc = v && rdy;
        if (acc) sb.push_back(d);
        @(posedge clk);
        #1;
        if (iss) begin
            chk("dout_valid", {31'd0, bus.dout_valid}, 32'd1);
            chk("issue_lane", {30'd0, bus.s1, bus.s0}, {30'd0, ln});
            if (sb.size() > 0) begin
                exp_d = sb.pop_front();
                chk("dout_data", {28'd0, bus.dout}, {28'd0, exp_d});
            end else begin
                chk("sb_underflow", sb.size(), 32'd1);
            end
            mptr = ln + 2'd1;
        end else begin
            chk("dout_valid", {31'd0, bus.dout_valid}, 32'd0);
            chk("dout_idle_zero", {28'd0, bus.dout}, 32'd0);
        end
        mb = mb & ~done;
        if (iss) mb[ln] = 1'b1;
        mpend = acc ? 1'b1 : (iss ? 1'b0 : mpend);
        chk("lane_busy", {28'd0, bus.lane_busy}, {28'd0, mb});
        last_acc = acc;
        bus.pe_done = 4'b0000;
    endtask

    initial begin
        int         sent;
        int         cyc;
        logic       v;
        logic [3:0] d;
        logic [3:0] dn;

        n_cmp        = 0;
        n_bad        = 0;
        last_acc     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'h0;
        bus.pe_done  = 4'h0;
        model_reset();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset values
        chk("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("rst_dout",       {28'd0, bus.dout}, 32'd0);
        chk("rst_sel",        {30'd0, bus.s1, bus.s0}, 32'd0);
        chk("rst_lane_busy",  {28'd0, bus.lane_busy}, 32'd0);
        chk("rst_in_ready",   {31'd0, bus.in_ready}, 32'd1);

        // Back-to-back stream fills all four lanes, fifth operand is held
        step(1'b1, 4'hA, 4'b0000);
        step(1'b1, 4'hB, 4'b0000);
        chk("seq_lane0", {30'd0, bus.s1, bus.s0}, 32'd0);
        step(1'b1, 4'hC, 4'b0000);
        chk("seq_lane1", {30'd0, bus.s1, bus.s0}, 32'd1);
        step(1'b1, 4'hD, 4'b0000);
        chk("seq_lane2", {30'd0, bus.s1, bus.s0}, 32'd2);
        step(1'b1, 4'hE, 4'b0000);
        chk("seq_lane3", {30'd0, bus.s1, bus.s0}, 32'd3);
        chk("full_busy",  {28'd0, bus.lane_busy}, 32'hF);
        chk("full_ready", {31'd0, bus.in_ready}, 32'd0);

        // Release lane 2: held operand issues two edges later to lane 2
        step(1'b0, 4'h0, 4'b0100);
        step(1'b0, 4'h0, 4'b0000);
        chk("rel2_lane", {30'd0, bus.s1, bus.s0}, 32'd2);
        chk("rel2_data", {28'd0, bus.dout}, 32'hE);
        chk("rel2_busy", {28'd0, bus.lane_busy}, 32'hF);

        // Free lane 1, then done on idle lane 1 with done on busy lane 0
        step(1'b0, 4'h0, 4'b0010);
        step(1'b0, 4'h0, 4'b0011);
        chk("ignore_idle_done", {28'd0, bus.lane_busy}, 32'hC);
        // ptr=3 with lane 3 busy wraps to lane 0
        step(1'b1, 4'h6, 4'b0000);
        step(1'b0, 4'h0, 4'b0000);
        chk("wrap_lane0", {30'd0, bus.s1, bus.s0}, 32'd0);
        step(1'b1, 4'h7, 4'b0000);
        step(1'b0, 4'h0, 4'b0000);
        chk("next_lane1", {30'd0, bus.s1, bus.s0}, 32'd1);
        step(1'b0, 4'h0, 4'b1111);

        // Random full-rate stream with random done pulses refilling lanes
        sent = 0;
        cyc  = 0;
        while ((sent < 100 || sb.size() != 0) && cyc < 5000) begin
            v  = (sent < 100) && ($urandom_range(0, 3) != 0);
            d  = 4'($urandom);
            dn = 4'($urandom) & 4'($urandom);
            step(v, d, dn);
            if (last_acc) sent++;
            cyc++;
        end
        chk("rand_sent",  sent, 32'd100);
        chk("rand_drain", sb.size(), 32'd0);

        // Build PENDING with lane_busy=0110, then reset asynchronously
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(1'b1, 4'h1, 4'b0000);
        step(1'b1, 4'h2, 4'b0000);
        step(1'b1, 4'h3, 4'b0000);
        step(1'b0, 4'h0, 4'b0000);
        step(1'b0, 4'h0, 4'b0001);
        step(1'b1, 4'h9, 4'b0000);
        chk("pre_rst_busy", {28'd0, bus.lane_busy}, 32'h6);
        chk("pre_rst_sel",  {30'd0, bus.s1, bus.s0}, 32'd2);
        bus.in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_busy",       {28'd0, bus.lane_busy}, 32'd0);
        chk("async_sel",        {30'd0, bus.s1, bus.s0}, 32'd0);
        chk("async_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("async_dout",       {28'd0, bus.dout}, 32'd0);
        chk("async_in_ready",   {31'd0, bus.in_ready}, 32'd1);
        model_reset();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Pending operand was discarded: nothing issues
        step(1'b0, 4'h0, 4'b0000);
        step(1'b1, 4'h5, 4'b0000);
        step(1'b0, 4'h0, 4'b0000);
        chk("post_rst_lane", {30'd0, bus.s1, bus.s0}, 32'd0);
        chk("post_rst_data", {28'd0, bus.dout}, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pe_dispatch
`default_nettype wire
